// File: rtl/wb_cpu_master.sv
// Byte-wide CPU request port bridged onto a 16-bit Wishbone Classic master.
// Each request runs one single-beat bus cycle with an ack timeout. Every output is a flop.
module wb_cpu_master #(
    parameter int unsigned WB_ADDR_WIDTH  = 24,
    parameter int unsigned WB_DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,

    input  logic                     cpu_req_i,
    input  logic                     cpu_we_i,
    input  logic [WB_ADDR_WIDTH:0]   cpu_addr_i,
    input  logic [7:0]               cpu_dat_i,
    output logic [7:0]               cpu_dat_o,
    output logic                     cpu_busy_o,
    output logic                     cpu_done_o,
    output logic                     cpu_err_o,

    output logic                     wb_cyc_o,
    output logic                     wb_stb_o,
    output logic                     wb_we_o,
    output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    output logic [1:0]               wb_sel_o,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    input  logic                     wb_ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       cyc_q, cyc_d;
    logic                       we_q, we_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [1:0]                 sel_q, sel_d;
    logic [7:0]                 rdat_q, rdat_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       err_q, err_d;
    logic [7:0]                 lane_c;

    // Byte lane picked by the latched select (lane 0 = bits 7:0).
    assign lane_c = sel_q[1] ? wb_dat_i[15:8] : wb_dat_i[7:0];

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    state_d = S_BUS;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    busy_d  = 1'b1;
                    we_d    = cpu_we_i;
                    adr_d   = cpu_addr_i[WB_ADDR_WIDTH:1];
                    sel_d   = cpu_addr_i[0] ? 2'b10 : 2'b01;
                    wdat_d  = WB_DATA_WIDTH'({cpu_dat_i, cpu_dat_i});
                end
            end
            S_BUS: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (wb_ack_i) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdat_d = lane_c;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    cyc_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        rdat_d = 8'hFF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                cyc_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= 2'b00;
            rdat_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = cyc_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = wdat_q;
    assign wb_sel_o   = sel_q;
    assign cpu_dat_o  = rdat_q;
    assign cpu_busy_o = busy_q;
    assign cpu_done_o = done_q;
    assign cpu_err_o  = err_q;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Bench for wb_cpu_master: per-transaction timeline model, directed literal cases, random traffic.
module tb_wb_cpu_master;

    localparam int unsigned AW = 24;
    localparam int          T  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req, we;
    logic [AW:0]   addr;
    logic [7:0]    din;
    logic [7:0]    cpu_dat_o;
    logic          cpu_busy_o, cpu_done_o, cpu_err_o;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [15:0]   wb_dat_o;
    logic [1:0]    wb_sel_o;
    logic [15:0]   wb_dat_i;
    logic          wb_ack_i;

    int checks   = 0;
    int failures = 0;

    // Stimulus knobs: ack index for the next accepted request, read data, overrides.
    int          k_sel;
    logic [15:0] rd_sel;
    bit          dir_mode, force_ack, chk_en;

    always #5 clk = ~clk;

    wb_cpu_master #(
        .WB_ADDR_WIDTH (AW),
        .WB_DATA_WIDTH (16),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cpu_req_i (req),
        .cpu_we_i  (we),
        .cpu_addr_i(addr),
        .cpu_dat_i (din),
        .cpu_dat_o (cpu_dat_o),
        .cpu_busy_o(cpu_busy_o),
        .cpu_done_o(cpu_done_o),
        .cpu_err_o (cpu_err_o),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: a transaction accepted in cycle acc strobes cycles acc+1..acc+len, completes in acc+len+1.
    int          cyc_n = 0;
    bit          have_txn = 0;
    bit          after_rst = 0;
    int          acc, k_cur, len;
    logic        m_we;
    logic [AW:0] m_addr;
    logic [7:0]  m_d;
    logic [15:0] m_rdata;
    logic        m_err = 1'b0;
    logic [7:0]  m_dout = 8'h00;

    function automatic bit in_stb(input int m);
        return have_txn && (m >= acc + 1) && (m <= acc + len);
    endfunction

    function automatic bit in_done(input int m);
        return have_txn && (m == acc + len + 1);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            have_txn  = 0;
            m_err     = 1'b0;
            m_dout    = 8'h00;
            after_rst = 1;
        end else begin
            after_rst = 0;
            if (have_txn && k_cur < T && cyc_n == acc + 1 + k_cur)
                m_rdata = wb_dat_i;
            if (!(in_stb(cyc_n) || in_done(cyc_n)) && req) begin
                have_txn = 1;
                acc      = cyc_n;
                k_cur    = k_sel;
                len      = (k_sel < T) ? k_sel + 1 : T;
                m_we     = we;
                m_addr   = addr;
                m_d      = din;
            end
        end
        cyc_n++;
        if (in_done(cyc_n)) begin
            m_err = (k_cur >= T);
            if (!m_we)
                m_dout = m_err ? 8'hFF : (m_addr[0] ? m_rdata[15:8] : m_rdata[7:0]);
        end
    end

    // Slave: ack only at the scheduled strobe index, random stray acks outside the bus window.
    always @(posedge clk) begin
        #1;
        wb_ack_i = force_ack
                || (have_txn && k_cur < T && cyc_n == acc + 1 + k_cur)
                || (!in_stb(cyc_n) && ($urandom_range(3) == 0));
        wb_dat_i = dir_mode ? rd_sel : 16'($urandom);
    end

    // Compare DUT against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc",  {31'b0, wb_cyc_o},   {31'b0, in_stb(cyc_n)});
            chk("stb",  {31'b0, wb_stb_o},   {31'b0, in_stb(cyc_n)});
            chk("busy", {31'b0, cpu_busy_o}, {31'b0, in_stb(cyc_n) || in_done(cyc_n)});
            chk("done", {31'b0, cpu_done_o}, {31'b0, in_done(cyc_n)});
            chk("err",  {31'b0, cpu_err_o},  {31'b0, m_err});
            chk("dat_o", 32'(cpu_dat_o), 32'(m_dout));
            if (in_stb(cyc_n)) begin
                chk("we",  {31'b0, wb_we_o}, {31'b0, m_we});
                chk("adr", 32'(wb_adr_o), 32'(m_addr[AW:1]));
                chk("sel", 32'(wb_sel_o), m_addr[0] ? 32'd2 : 32'd1);
                if (m_we) chk("wdat", 32'(wb_dat_o), 32'({m_d, m_d}));
            end
            if (after_rst) begin
                chk("rst_we",   {31'b0, wb_we_o}, 32'd0);
                chk("rst_adr",  32'(wb_adr_o), 32'd0);
                chk("rst_wdat", 32'(wb_dat_o), 32'd0);
                chk("rst_sel",  32'(wb_sel_o), 32'd0);
            end
        end
    end

    // One directed transaction; returns what the CPU side saw.
    task automatic do_txn(input logic t_we, input logic [AW:0] t_addr, input logic [7:0] t_d,
                          input int t_k, input logic [15:0] t_rd,
                          output int stb_cnt, output int lat, output logic t_err,
                          output logic [7:0] t_dout, output logic [AW-1:0] t_adr,
                          output logic [1:0] t_sel, output logic [15:0] t_wdat, output logic t_wwe);
        bit got;
        @(posedge clk); #1;
        req = 1'b1; we = t_we; addr = t_addr; din = t_d; k_sel = t_k; rd_sel = t_rd;
        @(posedge clk); #1;
        req = 1'b0;
        got = 0; lat = 0; stb_cnt = 0;
        t_err = 1'b0; t_dout = 8'h00; t_adr = '0; t_sel = 2'b00; t_wdat = 16'h0; t_wwe = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cpu_done_o) begin
                got = 1; t_err = cpu_err_o; t_dout = cpu_dat_o;
            end else if (wb_cyc_o) begin
                stb_cnt++; t_adr = wb_adr_o; t_sel = wb_sel_o; t_wdat = wb_dat_o; t_wwe = wb_we_o;
            end
        end
        if (!got) chk("done_wait_expired", 32'd0, 32'd1);
    endtask

    int          s_cnt, s_lat, n_done, gap, min_gap;
    logic        s_err, s_wwe, prev_cyc, seen_cyc;
    logic [7:0]  s_dout;
    logic [AW-1:0] s_adr;
    logic [1:0]  s_sel;
    logic [15:0] s_wdat;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; din = 8'h00;
        k_sel = 0; rd_sel = 16'h0; dir_mode = 1; force_ack = 0; chk_en = 0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("reset_cyc",  {31'b0, wb_cyc_o},   32'd0);
        chk("reset_busy", {31'b0, cpu_busy_o}, 32'd0);
        chk("reset_sel",  32'(wb_sel_o),       32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Byte write, ack on third strobe cycle.
        do_txn(1'b1, 25'h000003, 8'hA5, 2, 16'h0, s_cnt, s_lat, s_err, s_dout, s_adr, s_sel, s_wdat, s_wwe);
        chk("wr_adr", 32'(s_adr), 32'h1);
        chk("wr_sel", 32'(s_sel), 32'h2);
        chk("wr_wdat", 32'(s_wdat), 32'hA5A5);
        chk("wr_we", {31'b0, s_wwe}, 32'd1);
        chk("wr_stb_cycles", 32'(s_cnt), 32'd3);
        chk("wr_latency", 32'(s_lat), 32'd4);
        chk("wr_err", {31'b0, s_err}, 32'd0);

        // Byte reads from both lanes.
        do_txn(1'b0, 25'h000010, 8'h00, 0, 16'h1234, s_cnt, s_lat, s_err, s_dout, s_adr, s_sel, s_wdat, s_wwe);
        chk("rd0_sel", 32'(s_sel), 32'h1);
        chk("rd0_dat", 32'(s_dout), 32'h34);
        chk("rd0_we", {31'b0, s_wwe}, 32'd0);
        chk("rd0_latency", 32'(s_lat), 32'd2);
        do_txn(1'b0, 25'h000011, 8'h00, 1, 16'h1234, s_cnt, s_lat, s_err, s_dout, s_adr, s_sel, s_wdat, s_wwe);
        chk("rd1_sel", 32'(s_sel), 32'h2);
        chk("rd1_dat", 32'(s_dout), 32'h12);
        chk("rd1_adr", 32'(s_adr), 32'h8);

        // Timeout with no ack.
        do_txn(1'b0, 25'h000020, 8'h00, 100, 16'hBEEF, s_cnt, s_lat, s_err, s_dout, s_adr, s_sel, s_wdat, s_wwe);
        chk("to_stb_cycles", 32'(s_cnt), 32'd8);
        chk("to_err", {31'b0, s_err}, 32'd1);
        chk("to_dat", 32'(s_dout), 32'hFF);
        chk("to_latency", 32'(s_lat), 32'd9);

        // Ack in the last cycle before timeout.
        do_txn(1'b0, 25'h000020, 8'h00, 7, 16'hBEEF, s_cnt, s_lat, s_err, s_dout, s_adr, s_sel, s_wdat, s_wwe);
        chk("lastack_stb_cycles", 32'(s_cnt), 32'd8);
        chk("lastack_err", {31'b0, s_err}, 32'd0);
        chk("lastack_dat", 32'(s_dout), 32'hEF);

        // Request held high: one transaction per 3 cycles with ack at index 0.
        n_done = 0; min_gap = 1000; gap = 0; prev_cyc = 1'b0; seen_cyc = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            req = (i < 12); we = 1'b0; addr = 25'(i); k_sel = 0;
            @(negedge clk);
            if (cpu_done_o) n_done++;
            if (wb_cyc_o && !prev_cyc && seen_cyc && gap < min_gap) min_gap = gap;
            if (wb_cyc_o) begin seen_cyc = 1'b1; gap = 0; end
            else gap++;
            prev_cyc = wb_cyc_o;
            @(posedge clk); #1;
        end
        req = 1'b0;
        chk("b2b_done_count", 32'(n_done), 32'd4);
        chk("b2b_idle_gap", 32'(min_gap), 32'd2);

        // Reset during the second strobe cycle, then stray acks.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; addr = 25'h000055; din = 8'h3C; k_sel = 100;
        @(posedge clk); #1 req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_cyc_before", {31'b0, wb_cyc_o}, 32'd1);
        @(posedge clk); #1 rst = 1'b0; force_ack = 1;
        @(negedge clk);
        chk("midrst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("midrst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("midrst_busy", {31'b0, cpu_busy_o}, 32'd0);
        n_done = cpu_done_o ? 1 : 0;
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (cpu_done_o || wb_cyc_o) n_done++;
        end
        force_ack = 0;
        chk("midrst_no_done", 32'(n_done), 32'd0);

        // Random traffic against the model.
        dir_mode = 0;
        repeat (3000) begin
            @(posedge clk); #1;
            rst   = ($urandom_range(99) == 0);
            req   = ($urandom_range(1) == 1);
            we    = ($urandom_range(1) == 1);
            addr  = 25'($urandom);
            din   = 8'($urandom);
            k_sel = $urandom_range(9);
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cpu_master.md
WB_CPU_MASTER -- requirements
Module: wb_cpu_master

Interface
REQ-001 SHALL have parameter WB_ADDR_WIDTH, default 24, Wishbone word-address width.
REQ-002 SHALL have parameter WB_DATA_WIDTH, default 16, Wishbone data width; only 16 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, the maximum number of cycles a bus cycle may wait for ack.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
  - wb_clk_i  input  1  clock.
  - wb_rst_i  input  1  synchronous, active-high reset.
REQ-005 CPU side:
  - cpu_req_i  input  1  request strobe.
  - cpu_we_i  input  1  1 = write.
  - cpu_addr_i  input  WB_ADDR_WIDTH+1  byte address.
  - cpu_dat_i  input  8  write byte.
  - cpu_dat_o  output  8  read byte.
  - cpu_busy_o  output  1  transaction in progress.
  - cpu_done_o  output  1  one-cycle completion pulse.
  - cpu_err_o  output  1  completion was a timeout.
REQ-006 Wishbone Classic master side:
  - wb_cyc_o  output  1  cycle valid.
  - wb_stb_o  output  1  strobe.
  - wb_we_o  output  1  write enable.
  - wb_adr_o  output  WB_ADDR_WIDTH  word address.
  - wb_dat_o  output  16  write data.
  - wb_sel_o  output  2  byte select.
  - wb_dat_i  input  16  read data.
  - wb_ack_i  input  1  acknowledge.
REQ-007 All outputs SHALL be driven from registers.

Function
REQ-008 FSM states SHALL be IDLE, BUS and DONE.
REQ-009 In IDLE with cpu_req_i=1, the block SHALL latch we, address and data, and move to BUS on the next edge.
REQ-010 wb_cyc_o and wb_stb_o SHALL both assert exactly 1 cycle after an accepted request and stay high until the ack cycle or timeout.
REQ-011 Address mapping:
  - wb_adr_o SHALL equal cpu_addr_i[WB_ADDR_WIDTH:1].
  - wb_sel_o SHALL be 2'b01 when cpu_addr_i[0]=0 and 2'b10 when cpu_addr_i[0]=1 (lane 0 = bits 7:0).
REQ-012 On writes, wb_dat_o SHALL carry cpu_dat_i replicated on both byte lanes; on reads wb_we_o SHALL be 0.
REQ-013 wb_we_o, wb_adr_o, wb_sel_o and wb_dat_o SHALL stay stable for the whole BUS state.
REQ-014 In BUS with wb_ack_i=1, the block SHALL, on the next edge:
  - deassert wb_cyc_o and wb_stb_o;
  - pulse cpu_done_o for 1 cycle with cpu_err_o=0;
  - for reads, load cpu_dat_o with the selected lane of wb_dat_i sampled in the ack cycle;
  - enter DONE.
REQ-015 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-016 When the counter reaches TIMEOUT_CYCLES-1 without ack, the block SHALL, on the next edge:
  - drop cyc/stb;
  - pulse cpu_done_o with cpu_err_o=1;
  - load cpu_dat_o=8'hFF on reads;
  - enter DONE.
REQ-017 If ack and timeout coincide, ack SHALL win (cpu_err_o=0).
REQ-018 DONE SHALL last exactly 1 cycle with cyc/stb low, then return to IDLE. This guarantees at least one idle bus cycle between transactions.
REQ-019 cpu_busy_o SHALL be 1 from the cycle after acceptance through DONE, and 0 in IDLE.
REQ-020 cpu_req_i while not in IDLE SHALL be ignored and not queued.
REQ-021 wb_ack_i while not in BUS SHALL be ignored.
REQ-022 cpu_err_o and cpu_dat_o SHALL hold their values until the next completion.
REQ-023 Request-to-done latency SHALL be (ack cycle index relative to stb assertion) + 2 cycles.

Reset
REQ-024 While wb_rst_i=1 the block SHALL be in IDLE, the timeout counter SHALL be 0, and outputs SHALL be:
  - wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0;
  - cpu_dat_o=0, cpu_busy_o=0, cpu_done_o=0, cpu_err_o=0.
REQ-025 Reset asserted mid-BUS SHALL drop cyc/stb at the next edge and SHALL NOT produce a done pulse.
REQ-026 Reset SHALL take priority over cpu_req_i and wb_ack_i in the same cycle.

Verification
REQ-027 Byte write: addr 0x000003, data 0xA5, ack on the 3rd stb cycle -> wb_adr_o=0x000001, wb_sel_o=2'b10, wb_dat_o=0xA5A5, we=1; done 1 cycle after ack, err=0.
REQ-028 Byte read: addr 0x000010, slave returns 0x1234 with ack -> sel=2'b01, cpu_dat_o=0x34; with addr 0x000011 -> sel=2'b10, cpu_dat_o=0x12.
REQ-029 Timeout: TIMEOUT_CYCLES=8, no ack -> cyc/stb high for exactly 8 cycles, done with err=1, cpu_dat_o=0xFF.
REQ-030 Ack on the final timeout cycle -> err=0, data taken from wb_dat_i.
REQ-031 Back-to-back: cpu_req_i held high continuously -> second cycle starts only after DONE; at least 1 cycle with cyc=0 between cycles; no request lost or duplicated beyond one per IDLE visit.
REQ-032 Reset in the 2nd BUS cycle -> cyc/stb=0 next edge; no done pulse; stray ack afterwards ignored; busy=0.
